// File: rtl/regfile_pkg.sv
// Shared widths and types for the decode-side register file and its pending-write scoreboard.
package regfile_pkg;
    localparam int XLEN       = 32;
    localparam int NREGS      = 32;
    localparam int CNT_W      = 2;
    localparam int REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       xlen_t;
    typedef logic [CNT_W-1:0]      pend_cnt_t;

    localparam pend_cnt_t CNT_MAX = '1;

    function automatic logic cnt_busy(input pend_cnt_t c);
        return (c != '0);
    endfunction
endpackage

// File: rtl/regfile_scoreboard_sb.sv
// Per-register pending-write counters: issue increments, writeback decrements, saturating at both ends.
// x0 never counts; a writeback against an idle counter is flagged as a protocol error.
module regfile_scoreboard_sb
    import regfile_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      inc_en,
    input  reg_addr_t inc_rd,
    input  logic      dec_en,
    input  reg_addr_t dec_rd,
    input  reg_addr_t a1,
    input  reg_addr_t a2,
    input  reg_addr_t rd_d,
    output pend_cnt_t cnt1,
    output pend_cnt_t cnt2,
    output logic      full_rd,
    output logic      pending_any
);

    pend_cnt_t cnt_q [NREGS];
    pend_cnt_t cnt_d [NREGS];
    logic      inc_hit;
    logic      dec_hit;

    always_comb begin
        inc_hit = 1'b0;
        dec_hit = 1'b0;
        for (int r = 0; r < NREGS; r++) begin
            cnt_d[r] = cnt_q[r];
            inc_hit  = inc_en && (inc_rd == reg_addr_t'(r));
            dec_hit  = dec_en && (dec_rd == reg_addr_t'(r));
            if (r == 0) begin
                cnt_d[r] = '0;
            end else if (inc_hit && !dec_hit) begin
                if (cnt_q[r] != CNT_MAX) cnt_d[r] = cnt_q[r] + pend_cnt_t'(1);
            end else if (dec_hit && !inc_hit) begin
                // an unmatched writeback holds at zero rather than wrapping
                if (cnt_q[r] != '0) cnt_d[r] = cnt_q[r] - pend_cnt_t'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) cnt_q[r] <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        pending_any = 1'b0;
        for (int r = 0; r < NREGS; r++) begin
            pending_any = pending_any | cnt_busy(cnt_q[r]);
        end
    end

    assign cnt1    = cnt_q[a1];
    assign cnt2    = cnt_q[a2];
    assign full_rd = (cnt_q[rd_d] == CNT_MAX);

    underflow_chk: assert property (@(posedge clk) disable iff (reset)
        dec_en |-> (cnt_q[dec_rd] != '0));

endmodule

// File: rtl/regfile_scoreboard.sv
// Decode register file with writeback port and pending-write scoreboard driving the decode stall.
// REGFILE_BYPASS_EN adds write-through forwarding from WB and lets the retiring write clear the hazard.
module regfile_scoreboard
    import regfile_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  reg_addr_t A1,
    input  reg_addr_t A2,
    output xlen_t     RD1,
    output xlen_t     RD2,
    input  logic      IssueD,
    input  logic      RegWriteD,
    input  reg_addr_t RdD,
    input  logic      RegWriteW,
    input  reg_addr_t RdW,
    input  xlen_t     ResultW,
    output logic      StallD,
    output logic      PendingAny
);

    xlen_t     regs_q [NREGS];
    xlen_t     regs_d [NREGS];
    pend_cnt_t cnt1;
    pend_cnt_t cnt2;
    logic      full_rd;
    logic      wb_we;
    logic      retire1;
    logic      retire2;
    logic      hazard1;
    logic      hazard2;
    logic      full;
    logic      issue_wr;

    assign wb_we = RegWriteW && (RdW != '0);

    always_comb begin
        regs_d = regs_q;
        if (wb_we) regs_d[RdW] = ResultW;
        regs_d[0] = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign retire1 = wb_we && (RdW == A1) && (cnt1 == pend_cnt_t'(1));
    assign retire2 = wb_we && (RdW == A2) && (cnt2 == pend_cnt_t'(1));

    always_comb begin
        RD1 = (A1 == '0) ? '0 : regs_q[A1];
        RD2 = (A2 == '0) ? '0 : regs_q[A2];
        if (wb_we && (RdW == A1)) RD1 = ResultW;
        if (wb_we && (RdW == A2)) RD2 = ResultW;
    end
`else
    assign retire1 = 1'b0;
    assign retire2 = 1'b0;

    always_comb begin
        RD1 = (A1 == '0) ? '0 : regs_q[A1];
        RD2 = (A2 == '0) ? '0 : regs_q[A2];
    end
`endif

    // hazards use pre-issue counts, so an instruction never stalls on its own rd
    assign hazard1  = cnt_busy(cnt1) && !retire1;
    assign hazard2  = cnt_busy(cnt2) && !retire2;
    assign full     = RegWriteD && (RdD != '0) && full_rd;
    assign StallD   = IssueD && (hazard1 || hazard2 || full);
    assign issue_wr = IssueD && !StallD && RegWriteD && (RdD != '0);

    regfile_scoreboard_sb u_sb (
        .clk         (clk),
        .reset       (reset),
        .inc_en      (issue_wr),
        .inc_rd      (RdD),
        .dec_en      (wb_we),
        .dec_rd      (RdW),
        .a1          (A1),
        .a2          (A2),
        .rd_d        (RdD),
        .cnt1        (cnt1),
        .cnt2        (cnt2),
        .full_rd     (full_rd),
        .pending_any (PendingAny)
    );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard; expectations follow REGFILE_BYPASS_EN when defined.
module tb_regfile_scoreboard;
    import regfile_pkg::*;

    logic      clk;
    logic      reset;
    reg_addr_t A1, A2, RdD, RdW;
    xlen_t     RD1, RD2, ResultW;
    logic      IssueD, RegWriteD, RegWriteW;
    logic      StallD, PendingAny;

    int checks = 0;
    int errors = 0;

    regfile_scoreboard dut (
        .clk        (clk),
        .reset      (reset),
        .A1         (A1),
        .A2         (A2),
        .RD1        (RD1),
        .RD2        (RD2),
        .IssueD     (IssueD),
        .RegWriteD  (RegWriteD),
        .RdD        (RdD),
        .RegWriteW  (RegWriteW),
        .RdW        (RdW),
        .ResultW    (ResultW),
        .StallD     (StallD),
        .PendingAny (PendingAny)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // inputs change 1 time unit after the rising edge; outputs are sampled at the falling edge
    task automatic cyc();
        @(posedge clk);
        #1;
        IssueD    = 1'b0;
        RegWriteD = 1'b0;
        RdD       = '0;
        RegWriteW = 1'b0;
        RdW       = '0;
        ResultW   = '0;
        A1        = '0;
        A2        = '0;
    endtask

    task automatic settle();
        #4;
    endtask

    initial begin
        reset = 1'b1;
        IssueD = 1'b0; RegWriteD = 1'b0; RdD = '0;
        RegWriteW = 1'b0; RdW = '0; ResultW = '0;
        A1 = '0; A2 = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // reset state
        IssueD = 1'b1; A1 = 5'd5; A2 = 5'd0;
        settle();
        chk("reset_rd1", RD1, 32'h0);
        chk("reset_rd2", RD2, 32'h0);
        chk_bit("reset_stall", StallD, 1'b0);
        chk_bit("reset_pending", PendingAny, 1'b0);

        // basic write/read, preceded by a matching issue to rd 7
        cyc(); IssueD = 1'b1; RegWriteD = 1'b1; RdD = 5'd7;
        settle();
        chk_bit("issue7_accept", StallD, 1'b0);
        cyc();
        settle();
        chk_bit("issue7_pending", PendingAny, 1'b1);
        cyc(); RegWriteW = 1'b1; RdW = 5'd7; ResultW = 32'hDEADBEEF; A1 = 5'd7;
        settle();
`ifdef REGFILE_BYPASS_EN
        chk("wb7_same_cycle_rd1", RD1, 32'hDEADBEEF);
`else
        chk("wb7_same_cycle_rd1", RD1, 32'h0);
`endif
        cyc(); A1 = 5'd7;
        settle();
        chk("wb7_read_rd1", RD1, 32'hDEADBEEF);
        chk_bit("wb7_drained", PendingAny, 1'b0);
        cyc(); RegWriteW = 1'b1; RdW = 5'd0; ResultW = 32'h1234; A2 = 5'd0;
        settle();
        chk("x0_write_same_cycle", RD2, 32'h0);
        cyc(); A1 = 5'd0; A2 = 5'd7;
        settle();
        chk("x0_read", RD1, 32'h0);
        chk("x7_kept", RD2, 32'hDEADBEEF);

        // RAW stall on rd 3; the stalled instruction also targets rd 10 and must not count
        cyc(); IssueD = 1'b1; RegWriteD = 1'b1; RdD = 5'd3;
        settle();
        chk_bit("raw_issue_accept", StallD, 1'b0);
        cyc(); IssueD = 1'b1; RegWriteD = 1'b1; RdD = 5'd10; A1 = 5'd3;
        settle();
        chk_bit("raw_stall_c1", StallD, 1'b1);
        cyc(); IssueD = 1'b1; RegWriteD = 1'b1; RdD = 5'd10; A1 = 5'd3;
        settle();
        chk_bit("raw_stall_c2", StallD, 1'b1);
        cyc(); IssueD = 1'b1; A1 = 5'd3; RegWriteW = 1'b1; RdW = 5'd3; ResultW = 32'h55;
        settle();
`ifdef REGFILE_BYPASS_EN
        chk_bit("raw_wb_cycle_stall", StallD, 1'b0);
        chk("raw_wb_cycle_rd1", RD1, 32'h55);
`else
        chk_bit("raw_wb_cycle_stall", StallD, 1'b1);
        chk("raw_wb_cycle_rd1", RD1, 32'h0);
`endif
        cyc(); IssueD = 1'b1; A1 = 5'd3;
        settle();
        chk_bit("raw_after_wb_stall", StallD, 1'b0);
        chk("raw_after_wb_rd1", RD1, 32'h55);
        cyc();
        settle();
        chk_bit("raw_no_stray_inc", PendingAny, 1'b0);

        // three writes in flight to rd 9, then full
        for (int i = 0; i < 3; i++) begin
            cyc(); IssueD = 1'b1; RegWriteD = 1'b1; RdD = 5'd9;
            settle();
            chk_bit("multi_issue_accept", StallD, 1'b0);
        end
        cyc(); IssueD = 1'b1; RegWriteD = 1'b1; RdD = 5'd9;
        settle();
        chk_bit("full_stall", StallD, 1'b1);
        cyc(); IssueD = 1'b1; RegWriteD = 1'b1; RdD = 5'd9;
        RegWriteW = 1'b1; RdW = 5'd9; ResultW = 32'h99;
        settle();
        chk_bit("full_stall_during_wb", StallD, 1'b1);
        cyc(); IssueD = 1'b1; RegWriteD = 1'b1; RdD = 5'd9;
        settle();
        chk_bit("full_after_wb_accept", StallD, 1'b0);
        cyc(); IssueD = 1'b1; RegWriteD = 1'b1; RdD = 5'd9;
        settle();
        chk_bit("full_again", StallD, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc(); RegWriteW = 1'b1; RdW = 5'd9; ResultW = 32'h900 + 32'(i);
        end
        cyc(); A1 = 5'd9;
        settle();
        chk_bit("multi_drained", PendingAny, 1'b0);
        chk("multi_last_value", RD1, 32'h902);

        // simultaneous increment and decrement of rd 4
        cyc(); IssueD = 1'b1; RegWriteD = 1'b1; RdD = 5'd4;
        settle();
        chk_bit("incdec_first_issue", StallD, 1'b0);
        cyc(); IssueD = 1'b1; RegWriteD = 1'b1; RdD = 5'd4;
        RegWriteW = 1'b1; RdW = 5'd4; ResultW = 32'h44;
        settle();
        chk_bit("incdec_issue_accept", StallD, 1'b0);
        cyc(); IssueD = 1'b1; A1 = 5'd4;
        settle();
        chk_bit("incdec_pending", PendingAny, 1'b1);
        chk_bit("incdec_still_busy", StallD, 1'b1);
        cyc(); RegWriteW = 1'b1; RdW = 5'd4; ResultW = 32'h45;
        cyc(); A1 = 5'd4;
        settle();
        chk_bit("incdec_drained", PendingAny, 1'b0);
        chk("incdec_value", RD1, 32'h45);

        // reset mid-operation with cnt[3]=2, cnt[9]=1 and a WB in the reset cycle
        cyc(); IssueD = 1'b1; RegWriteD = 1'b1; RdD = 5'd3;
        cyc(); IssueD = 1'b1; RegWriteD = 1'b1; RdD = 5'd3;
        cyc(); IssueD = 1'b1; RegWriteD = 1'b1; RdD = 5'd9;
        cyc(); A1 = 5'd3; IssueD = 1'b1;
        settle();
        chk_bit("pre_reset_stall", StallD, 1'b1);
        cyc(); reset = 1'b1; RegWriteW = 1'b1; RdW = 5'd3; ResultW = 32'hAA;
        settle();
        chk_bit("pre_reset_pending", PendingAny, 1'b1);
        cyc(); reset = 1'b0; IssueD = 1'b1; A1 = 5'd3; A2 = 5'd9;
        settle();
        chk_bit("post_reset_pending", PendingAny, 1'b0);
        chk_bit("post_reset_stall", StallD, 1'b0);
        chk("post_reset_rd1", RD1, 32'h0);
        chk("post_reset_rd2", RD2, 32'h0);
        cyc(); A1 = 5'd7; A2 = 5'd4;
        settle();
        chk("post_reset_x7", RD1, 32'h0);
        chk("post_reset_x4", RD2, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Decode-side register file that supplies RD1/RD2 into the ID/EX pipeline register.
- Accepts writeback from the WB stage.
- Tracks in-flight destination registers with a per-register pending-write scoreboard. Raises a decode stall when a source operand is not yet written back.
- Closes the loop between execute-stage capture and writeback in the hazard-free pipeline.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers; x0 is hardwired to zero.
- CNT_W, 2, width of each per-register pending counter; allows up to 3 writes in flight to one rd (EX, MEM, WB).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- A1  input  5  source register 1 address (decode).
- A2  input  5  source register 2 address (decode).
- RD1  output  XLEN  source 1 read data, combinational.
- RD2  output  XLEN  source 2 read data, combinational.
- IssueD  input  1  decode instruction advances to EX this cycle (before stall gating).
- RegWriteD  input  1  decode instruction writes a destination register.
- RdD  input  5  decode destination register.
- RegWriteW  input  1  writeback write enable.
- RdW  input  5  writeback destination register.
- ResultW  input  XLEN  writeback data.
- StallD  output  1  decode must hold; the issue is not accepted.
- PendingAny  output  1  OR of all pending counters ≠ 0 (drain status).

Behaviour:
- Reset (synchronous, active-high; evaluated at the clk edge):
  - all registers cleared to 0 and all pending counters cleared to 0.
  - after reset: RD1 = RD2 = 0, StallD = 0, PendingAny = 0.
  - reset mid-operation discards all in-flight scoreboard state. Any WB write in the reset cycle is dropped.
- Write:
  - on posedge clk, if RegWriteW and RdW ≠ 0, then reg[RdW] <= ResultW.
  - writes to x0 are ignored.
  - WB decrements cnt[RdW] when RegWriteW and RdW ≠ 0.
  - WB with cnt[RdW] = 0 is a protocol error: the counter holds at 0 (no underflow), the data write still occurs, and the simulation assertion fires.
- Read:
  - RD1 = (A1 = 0) ? 0 : reg[A1]; RD2 likewise.
  - purely combinational from array state; bypass per Optional Feature.
- Scoreboard:
  - busy(r) = cnt[r] ≠ 0. x0 is never busy.
  - hazard1 = busy(A1) and not bypass-resolved; hazard2 likewise for A2.
  - full = RegWriteD and RdD ≠ 0 and cnt[RdD] = 2^CNT_W − 1.
  - StallD = IssueD and (hazard1 or hazard2 or full).
  - issue accepted = IssueD and not StallD.
  - an accepted issue with RegWriteD and RdD ≠ 0 increments cnt[RdD].
- Simultaneous events:
  - increment and decrement of the same register in one cycle leave cnt unchanged.
  - a write to reg[r] and a read of r in the same cycle: without bypass the read returns the old value and stall is held if cnt[r] = 1 before the edge. With bypass, see Optional Feature.
  - the same A1/A2 and RdD in one instruction: the hazard check uses pre-issue counts. The own rd never stalls itself.
- Latency: write visible via array one cycle after the WB edge. StallD is combinational from the current state and inputs.
- PendingAny is combinational from the counters.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - write-through forwarding: if RegWriteW and RdW = A1 ≠ 0, then RD1 = ResultW (same for RD2).
  - hazardN is suppressed when the WB is writing that source and cnt = 1; that is the last pending write retiring this cycle.
- Undefined:
  - no forwarding.
  - hazardN = busy(AN); the stall persists until the cycle after the final writeback.

Decomposition:
- Package regfile_pkg: XLEN, NREGS, CNT_W, REG_ADDR_W = 5, typedef reg_addr_t (logic [4:0]), typedef xlen_t (logic [XLEN−1:0]), typedef pend_cnt_t (logic [CNT_W−1:0]).
- Sub-module scoreboard: counter array, increment/decrement/saturation, busy/full/PendingAny generation.
- The top module holds the storage array, read muxes, the bypass logic and the StallD combination.

Test Plan:
- Reset then read: assert reset for 2 cycles; set A1 = 5, A2 = 0 -> RD1 = 0, RD2 = 0, StallD = 0, PendingAny = 0.
- Basic write/read, no pending: RegWriteW = 1, RdW = 7, ResultW = 0xDEADBEEF; next cycle A1 = 7 -> RD1 = 0xDEADBEEF. A write to RdW = 0 with 0x1234 leaves x0 reading 0.
- RAW stall: issue RegWriteD, RdD = 3. Next cycle IssueD with A1 = 3 -> StallD = 1 and no increment. WB rd 3 = 0x55 three cycles later.
  - with bypass: StallD drops in the WB cycle and RD1 = 0x55.
  - without bypass: StallD drops one cycle later and RD1 = 0x55.
- Multiple in flight: issue rd 9 three times back-to-back -> cnt = 3. A fourth issue to rd 9 -> StallD = 1 (full).
  - after one WB, cnt = 2 and the fourth issue is accepted.
- Simultaneous inc/dec: in the same cycle issue rd 4 and WB rd 4 with cnt[4] = 1 -> cnt[4] stays 1 and PendingAny stays 1.
- Reset mid-operation: with cnt[3] = 2 and cnt[9] = 1 pending, assert reset together with WB rd 3 = 0xAA -> all counters 0, StallD = 0, reg[3] = 0.
